md5_msg_padder: RTL and testbench
=================================

// Module: md5_msg_padder
// PURPOSE
//  Producer side of the MD5 message-block interface: accepts a byte stream and emits padded 512-bit blocks
//  (16 x 32-bit words) to the MD5 compression core. Applies RFC1321 padding (0x80, zero fill, 64-bit
//  little-endian bit length in words 14/15), inserts an extra block when padding overflows, and flags the final block.
// PARAMETERS
//  LEN_W  64  width of internal bit-length counter (8..64); unused upper bits of the length field are 0
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       asynchronous, active-high reset
//  data_i       in   8       message byte
//  valid_i      in   1       data_i valid
//  last_i       in   1       data_i is final byte of message (qualified by valid_i)
//  ready_o      out  1       padder accepts a byte this cycle (valid_i & ready_o = transfer)
//  blk_o        out  32x16   block words [0:15], word 0 = first message bytes
//  blk_valid_o  out  1       blk_o valid; held with blk_o stable until blk_ready_i
//  blk_ready_i  in   1       core takes block (blk_valid_o & blk_ready_i = transfer)
//  blk_last_o   out  1       block is final block of the message (qualified by blk_valid_o)
// BEHAVIOUR
//  - Reset (async, any state): state=FILL, byte count=0, bit length=0, buffer=0, blk_valid_o=0, blk_last_o=0, ready_o=0 during reset, 1 after.
//  - States: FILL, PAD, EMIT, EXTRA.
//  - FILL: ready_o=1. Byte k of block (k=0..63) written to word k>>2, lanes bits[8*(k&3)+:8]; byte count++, bit length += 8.
//      64th byte, last_i=0 -> EMIT (blk_last_o=0). last_i=1 on byte 1..63 -> PAD. last_i=1 on 64th byte -> EMIT
//      (blk_last_o=0) with extra-pending set.
//  - PAD (1 cycle, ready_o=0): byte at count = 8'h80, bytes above count = 0. If count<=55: words 14/15 = bit length
//      low/high, blk_last_o=1, -> EMIT. Else: -> EMIT (blk_last_o=0) with extra-pending set.
//  - EMIT: blk_valid_o=1, ready_o=0, blk_o frozen. On blk_ready_i: extra-pending -> EXTRA; else if blk_last_o -> FILL,
//      bit length cleared; else -> FILL (count=0, buffer cleared).
//  - EXTRA (1 cycle): words 0..13 = 0 except byte 0 = 8'h80 iff the 0x80 was not yet placed (message length multiple
//      of 64); words 14/15 = bit length; blk_last_o=1; clear extra-pending -> EMIT.
//  - Latency: 64th byte accepted -> blk_valid_o next cycle; last byte (non-64th) accepted -> blk_valid_o 2 cycles later.
//  - Bit length wraps modulo 2^LEN_W; zero-length messages are out of scope (last_i always accompanies a byte).
//  - valid_i ignored when ready_o=0; no bytes lost: upstream must hold data until ready_o.
//  - blk_ready_i without blk_valid_o ignored. Throughput: one byte/cycle in FILL, no overlap with EMIT.
// CONFIGURATION
//  MD5_PAD_BSWAP_EN defined: big-endian packing (byte k at bits[8*(3-(k&3))+:8]), 0x80 placed big-endian, length as
//      64-bit big-endian (word 14 = high, word 15 = low) -- SHA-1/SHA-256 compatible framing.
//  Not defined: MD5 little-endian packing and length order as above.
// STRUCTURE
//  md5_pkg: state enum (FILL, PAD, EMIT, EXTRA), BLK_WORDS=16, BLK_BYTES=64, LEN_POS=56, PAD_BYTE=8'h80, blk_t typedef.
//  Sub-module md5_pad_len_cnt: LEN_W-bit bit-length counter (+8 per byte, sync clear, async reset).
//  Byte buffer, lane insert, pad/length overlay and FSM in md5_msg_padder.
// TESTING
//  "abc" (61,62,63, last on 63) -> 1 block: w0=32'h80636261, w1..w13=0, w14=32'h18, w15=0, blk_last_o=1, 2-cycle latency.
//  55 bytes 8'h00 -> 1 block: w13=32'h80000000, w14=32'h1B8, w15=0, blk_last_o=1.
//  56 bytes 8'h00 -> 2 blocks: 1st w14=32'h00000080, w15=0, last=0; 2nd w0..w13=0, w14=32'h1C0, last=1.
//  64 bytes 8'h00 -> 2 blocks: 1st all 0, last=0; 2nd w0=32'h80, w14=32'h200, last=1.
//  blk_ready_i low 5 cycles in EMIT -> blk_o/blk_valid_o stable, ready_o=0; valid_i bytes not accepted.
//  rst_i pulsed after 10 bytes -> outputs cleared at once; next "abc" gives first-test block exactly.
//  With MD5_PAD_BSWAP_EN, "abc" -> w0=32'h61626380, w14=0, w15=32'h18.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padder and its block interface.
package md5_pkg;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT,
        EXTRA
    } state_t;

    localparam int BLK_WORDS = 16;
    localparam int BLK_BYTES = 64;
    localparam int LEN_POS   = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [BLK_WORDS-1:0][31:0] blk_t;

endpackage

// File: rtl/md5_msg_padder_if.sv
// Byte-stream input and padded-block output handshakes of the MD5 message padder.
interface md5_msg_padder_if;
    import md5_pkg::*;

    logic [7:0] data_i;
    logic       valid_i;
    logic       last_i;
    logic       ready_o;
    blk_t       blk_o;
    logic       blk_valid_o;
    logic       blk_ready_i;
    logic       blk_last_o;

    // The master sources message bytes and sinks finished blocks.
    modport master (
        output data_i, valid_i, last_i, blk_ready_i,
        input  ready_o, blk_o, blk_valid_o, blk_last_o
    );

    modport slave (
        input  data_i, valid_i, last_i, blk_ready_i,
        output ready_o, blk_o, blk_valid_o, blk_last_o
    );

endinterface

// File: rtl/md5_pad_len_cnt.sv
// Running message bit-length counter: +8 per accepted byte, synchronous clear, async reset.
module md5_pad_len_cnt #(
    parameter int LEN_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [LEN_W-1:0] len_o
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    always_comb begin
        len_d = len_q;
        if (clr_i) begin
            len_d = '0;
        end else if (inc_i) begin
            len_d = len_q + LEN_W'(8);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    assign len_o = len_q;

endmodule

// File: rtl/md5_msg_padder.sv
// Packs a byte stream into padded 512-bit MD5 blocks with an optional overflow block.
// Define MD5_PAD_BSWAP_EN for big-endian (SHA-style) byte packing and length order.
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    md5_msg_padder_if.slave   bus
);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    blk_t       buf_q, buf_d;
    logic       last_q, last_d;
    logic       extra_q, extra_d;
    logic       pad_done_q, pad_done_d;
    logic       ready_q, ready_d;
    logic       blk_valid_q, blk_valid_d;

    logic             len_inc;
    logic             len_clr;
    logic [LEN_W-1:0] len;
    logic [63:0]      len64;
    logic [31:0]      len_w14;
    logic [31:0]      len_w15;

    md5_pad_len_cnt #(
        .LEN_W (LEN_W)
    ) u_len_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (len_inc),
        .clr_i (len_clr),
        .len_o (len)
    );

    function automatic logic [4:0] lane_off(input logic [1:0] k);
`ifdef MD5_PAD_BSWAP_EN
        return {~k, 3'b000};
`else
        return {k, 3'b000};
`endif
    endfunction

    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = len;
`ifdef MD5_PAD_BSWAP_EN
        len_w14 = len64[63:32];
        len_w15 = len64[31:0];
`else
        len_w14 = len64[31:0];
        len_w15 = len64[63:32];
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        last_d     = last_q;
        extra_d    = extra_q;
        pad_done_d = pad_done_q;
        len_inc    = 1'b0;
        len_clr    = 1'b0;

        case (state_q)
            FILL: begin
                if (ready_q && bus.valid_i) begin
                    buf_d[cnt_q[5:2]][lane_off(cnt_q[1:0]) +: 8] = bus.data_i;
                    cnt_d   = cnt_q + 6'd1;
                    len_inc = 1'b1;
                    if (cnt_q == 6'(BLK_BYTES - 1)) begin
                        // A message ending exactly on a block boundary still needs a pad block.
                        state_d    = EMIT;
                        last_d     = 1'b0;
                        extra_d    = bus.last_i;
                        pad_done_d = 1'b0;
                    end else if (bus.last_i) begin
                        state_d = PAD;
                    end
                end
            end

            PAD: begin
                for (int i = 0; i < BLK_BYTES; i++) begin
                    if (i == int'(cnt_q)) begin
                        buf_d[i[5:2]][lane_off(i[1:0]) +: 8] = PAD_BYTE;
                    end else if (i > int'(cnt_q)) begin
                        buf_d[i[5:2]][lane_off(i[1:0]) +: 8] = 8'h00;
                    end
                end
                pad_done_d = 1'b1;
                if (int'(cnt_q) < LEN_POS) begin
                    buf_d[14] = len_w14;
                    buf_d[15] = len_w15;
                    last_d    = 1'b1;
                end else begin
                    last_d  = 1'b0;
                    extra_d = 1'b1;
                end
                state_d = EMIT;
            end

            EMIT: begin
                if (bus.blk_ready_i) begin
                    if (extra_q) begin
                        state_d = EXTRA;
                    end else begin
                        state_d    = FILL;
                        cnt_d      = '0;
                        buf_d      = '0;
                        last_d     = 1'b0;
                        pad_done_d = 1'b0;
                        len_clr    = last_q;
                    end
                end
            end

            EXTRA: begin
                buf_d = '0;
                if (!pad_done_q) begin
                    buf_d[0][lane_off(2'd0) +: 8] = PAD_BYTE;
                end
                buf_d[14]  = len_w14;
                buf_d[15]  = len_w15;
                last_d     = 1'b1;
                extra_d    = 1'b0;
                pad_done_d = 1'b1;
                state_d    = EMIT;
            end

            default: begin
                state_d = FILL;
            end
        endcase

        ready_d     = (state_d == FILL);
        blk_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            buf_q       <= '0;
            last_q      <= 1'b0;
            extra_q     <= 1'b0;
            pad_done_q  <= 1'b0;
            ready_q     <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            last_q      <= last_d;
            extra_q     <= extra_d;
            pad_done_q  <= pad_done_d;
            ready_q     <= ready_d;
            blk_valid_q <= blk_valid_d;
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.blk_o       = buf_q;
    assign bus.blk_valid_o = blk_valid_q;
    assign bus.blk_last_o  = last_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: known messages against hand-computed padded blocks.
// Expected words follow MD5_PAD_BSWAP_EN when it is defined.
module tb_md5_msg_padder;
    import md5_pkg::*;

`ifdef MD5_PAD_BSWAP_EN
    localparam logic [31:0] ABC_W0 = 32'h61626380;
    localparam logic [31:0] PAD_L3 = 32'h00000080;
    localparam logic [31:0] PAD_L0 = 32'h80000000;
`else
    localparam logic [31:0] ABC_W0 = 32'h80636261;
    localparam logic [31:0] PAD_L3 = 32'h80000000;
    localparam logic [31:0] PAD_L0 = 32'h00000080;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md5_msg_padder_if bus();

    md5_msg_padder #(
        .LEN_W (64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int compCount = 0;
    int failCount = 0;
    logic [7:0] msgQ[$];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Entered and left on a falling edge; the transfer happens on the rising edge in between.
    task automatic sendByte(input logic [7:0] d, input bit l);
        int budget = 0;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        bus.last_i  = l;
        while (bus.ready_o !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (bus.ready_o !== 1'b1) begin
            checkOutput("ready_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic applyStimulus();
        foreach (msgQ[i]) begin
            sendByte(msgQ[i], i == msgQ.size() - 1);
        end
    endtask

    task automatic getBlock(input string tag, output blk_t b, output bit bl, output int lat);
        lat = 0;
        while (bus.blk_valid_o !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (bus.blk_valid_o !== 1'b1) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
            b  = '0;
            bl = 1'b0;
            return;
        end
        b  = bus.blk_o;
        bl = bus.blk_last_o;
        bus.blk_ready_i = 1'b1;
        @(negedge clk);
        bus.blk_ready_i = 1'b0;
    endtask

    task automatic checkBlock(input string tag, input blk_t got, input bit gotLast,
                              input blk_t exp, input bit expLast);
        for (int w = 0; w < BLK_WORDS; w++) begin
            checkOutput($sformatf("%s_w%0d", tag, w), 64'(got[w]), 64'(exp[w]));
        end
        checkOutput({tag, "_last"}, 64'(gotLast), 64'(expLast));
    endtask

    function automatic blk_t withLen(input blk_t b, input logic [63:0] len);
        blk_t r = b;
`ifdef MD5_PAD_BSWAP_EN
        r[14] = len[63:32];
        r[15] = len[31:0];
`else
        r[14] = len[31:0];
        r[15] = len[63:32];
`endif
        return r;
    endfunction

    task automatic loadZeros(input int n);
        msgQ.delete();
        for (int i = 0; i < n; i++) msgQ.push_back(8'h00);
    endtask

    task automatic loadAbc();
        msgQ.delete();
        msgQ.push_back(8'h61);
        msgQ.push_back(8'h62);
        msgQ.push_back(8'h63);
    endtask

    initial begin
        blk_t got;
        blk_t exp;
        blk_t expAbc;
        blk_t snap;
        bit   gotLast;
        int   lat;
        int   t;

        bus.data_i      = 8'h00;
        bus.valid_i     = 1'b0;
        bus.last_i      = 1'b0;
        bus.blk_ready_i = 1'b0;

        expAbc    = '0;
        expAbc[0] = ABC_W0;
        expAbc    = withLen(expAbc, 64'd24);

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(bus.ready_o), 64'd0);
        checkOutput("rst_blk_valid", 64'(bus.blk_valid_o), 64'd0);
        checkOutput("rst_blk_last", 64'(bus.blk_last_o), 64'd0);
        checkOutput("rst_blk_zero", 64'(|bus.blk_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        loadAbc();
        applyStimulus();
        getBlock("abc", got, gotLast, lat);
        checkOutput("abc_latency", 64'(lat), 64'd1);
        checkBlock("abc", got, gotLast, expAbc, 1'b1);

        loadZeros(55);
        applyStimulus();
        getBlock("z55", got, gotLast, lat);
        exp     = '0;
        exp[13] = PAD_L3;
        exp     = withLen(exp, 64'h1B8);
        checkBlock("z55", got, gotLast, exp, 1'b1);

        loadZeros(56);
        applyStimulus();
        getBlock("z56a", got, gotLast, lat);
        exp     = '0;
        exp[14] = PAD_L0;
        checkBlock("z56a", got, gotLast, exp, 1'b0);
        getBlock("z56b", got, gotLast, lat);
        exp = withLen('0, 64'h1C0);
        checkBlock("z56b", got, gotLast, exp, 1'b1);

        loadZeros(64);
        applyStimulus();
        getBlock("z64a", got, gotLast, lat);
        checkOutput("z64_latency", 64'(lat), 64'd0);
        checkBlock("z64a", got, gotLast, '0, 1'b0);
        getBlock("z64b", got, gotLast, lat);
        exp    = '0;
        exp[0] = PAD_L0;
        exp    = withLen(exp, 64'h200);
        checkBlock("z64b", got, gotLast, exp, 1'b1);

        // Hold off the block sink while offering a stray byte.
        loadAbc();
        applyStimulus();
        t = 0;
        while (bus.blk_valid_o !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("stall_enter", 64'(bus.blk_valid_o), 64'd1);
        snap        = bus.blk_o;
        bus.data_i  = 8'hAA;
        bus.valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(bus.blk_valid_o), 64'd1);
            checkOutput("stall_ready", 64'(bus.ready_o), 64'd0);
            checkOutput("stall_blk_stable", 64'(bus.blk_o === snap), 64'd1);
        end
        bus.valid_i = 1'b0;
        getBlock("stall", got, gotLast, lat);
        checkBlock("stall", got, gotLast, expAbc, 1'b1);

        loadAbc();
        applyStimulus();
        getBlock("abc2", got, gotLast, lat);
        checkBlock("abc2", got, gotLast, expAbc, 1'b1);

        for (int i = 0; i < 10; i++) sendByte(8'h11, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 64'(bus.ready_o), 64'd0);
        checkOutput("mid_rst_blk_valid", 64'(bus.blk_valid_o), 64'd0);
        checkOutput("mid_rst_blk_last", 64'(bus.blk_last_o), 64'd0);
        checkOutput("mid_rst_blk_zero", 64'(|bus.blk_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        loadAbc();
        applyStimulus();
        getBlock("abc_post_rst", got, gotLast, lat);
        checkOutput("abc_post_rst_latency", 64'(lat), 64'd1);
        checkBlock("abc_post_rst", got, gotLast, expAbc, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
